// File: rtl/lru_pkg.sv
// Shared sizing defaults and controller state encoding for the per-set LRU
// replacement controller and its helpers.
package lru_pkg;

  localparam int LRU_WAYS = 8;
  localparam int LRU_CW   = 3;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_FLUSH  = 3'd2,
    ST_UPDATE = 3'd3,
    ST_RESP   = 3'd4
  } lru_state_e;

endpackage

// File: rtl/lru_victim_find.sv
// Combinational lowest-index zero finder over the packed counter bank.
// When no counter is zero, idx falls back to way 0 and found is low.
module lru_victim_find
  import lru_pkg::*;
#(
  parameter int WAYS = LRU_WAYS,
  parameter int CW   = LRU_CW
) (
  input  logic [WAYS*CW-1:0] cnt,
  output logic               found,
  output logic [CW-1:0]      idx
);

  logic [WAYS-1:0] zero_s;

  // Flag each way whose counter is zero.
  always_comb begin
    zero_s = {WAYS{1'b0}};
    for (int j = 0; j < WAYS; j++) begin
      zero_s[j] = ~|cnt[j*CW +: CW];
    end
  end

  // Scan from the top so the lowest-index zero way wins.
  always_comb begin
    idx   = {CW{1'b0}};
    found = |zero_s;
    for (int j = WAYS - 1; j >= 0; j--) begin
      idx = zero_s[j] ? CW'(j) : idx;
    end
  end

endmodule

// File: rtl/lru_replace_ctrl.sv
// Per-set LRU controller: picks the hit way or miss victim and drives the
// load/decrement/reset strobes of the negedge line-counter bank.
module lru_replace_ctrl
  import lru_pkg::*;
#(
  parameter int WAYS = LRU_WAYS,
  parameter int CW   = LRU_CW,
  parameter int MRU  = WAYS - 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_hit,
  input  logic [CW-1:0]      req_way,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [CW-1:0]      rsp_way,
  input  logic [WAYS*CW-1:0] cnt_in,
  output logic               cnt_enable,
  output logic               cnt_reset,
  output logic [WAYS-1:0]    cnt_load,
  output logic [CW-1:0]      cnt_load_value,
  output logic [WAYS-1:0]    cnt_decrement
);

  localparam logic [CW-1:0] MRU_V = CW'(MRU);

  lru_state_e        state_r;
  lru_state_e        state_s;
  logic [CW-1:0]     way_r;
  logic [CW-1:0]     way_s;

  logic [CW-1:0]     cnt_s [WAYS];
  logic              victim_found_s;
  logic [CW-1:0]     victim_idx_s;
  logic [CW-1:0]     sel_way_s;
  logic [CW-1:0]     sel_val_s;
  logic [WAYS-1:0]   load_mask_s;
  logic [WAYS-1:0]   dec_mask_s;

  logic              req_ready_s;
  logic              rsp_valid_s;
  logic [CW-1:0]     rsp_way_s;
  logic              cnt_enable_s;
  logic              cnt_reset_s;
  logic [WAYS-1:0]   cnt_load_s;
  logic [CW-1:0]     cnt_load_value_s;
  logic [WAYS-1:0]   cnt_decrement_s;

  lru_victim_find #(
    .WAYS (WAYS),
    .CW   (CW)
  ) u_victim (
    .cnt   (cnt_in),
    .found (victim_found_s),
    .idx   (victim_idx_s)
  );

  // Unpack the counter bank into per-way values.
  always_comb begin
    for (int j = 0; j < WAYS; j++) begin
      cnt_s[j] = cnt_in[j*CW +: CW];
    end
  end

  // Accessed way and the masks that keep the nonzero counters distinct.
  always_comb begin
    sel_way_s   = req_hit ? req_way : (victim_found_s ? victim_idx_s : {CW{1'b0}});
    sel_val_s   = cnt_s[sel_way_s];
    load_mask_s = {{(WAYS-1){1'b0}}, 1'b1} << sel_way_s;
    dec_mask_s  = {WAYS{1'b0}};
    for (int j = 0; j < WAYS; j++) begin
      dec_mask_s[j] = (CW'(j) != sel_way_s) && (cnt_s[j] > sel_val_s);
    end
  end

  // Next state plus the output values for the cycle spent in that state.
  always_comb begin
    state_s          = state_r;
    way_s            = way_r;
    req_ready_s      = 1'b0;
    rsp_valid_s      = 1'b0;
    rsp_way_s        = rsp_way;
    cnt_enable_s     = 1'b0;
    cnt_reset_s      = 1'b0;
    cnt_load_s       = {WAYS{1'b0}};
    cnt_load_value_s = {CW{1'b0}};
    cnt_decrement_s  = {WAYS{1'b0}};
    case (state_r)
      ST_INIT: begin
        // Hold INIT for one visible clear pulse, then open for requests.
        if (cnt_reset) begin
          state_s     = ST_IDLE;
          req_ready_s = 1'b1;
        end else begin
          cnt_enable_s = 1'b1;
          cnt_reset_s  = 1'b1;
        end
      end
      ST_IDLE: begin
        if (flush) begin
          state_s      = ST_FLUSH;
          cnt_enable_s = 1'b1;
          cnt_reset_s  = 1'b1;
        end else if (req_valid) begin
          state_s          = ST_UPDATE;
          way_s            = sel_way_s;
          cnt_enable_s     = 1'b1;
          cnt_load_s       = load_mask_s;
          cnt_load_value_s = MRU_V;
          cnt_decrement_s  = dec_mask_s;
        end else begin
          req_ready_s = 1'b1;
        end
      end
      ST_FLUSH: begin
        state_s     = ST_IDLE;
        req_ready_s = 1'b1;
      end
      ST_UPDATE: begin
        state_s     = ST_RESP;
        rsp_valid_s = 1'b1;
        rsp_way_s   = way_r;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_s     = ST_IDLE;
          req_ready_s = 1'b1;
        end else begin
          rsp_valid_s = 1'b1;
        end
      end
      default: begin
        state_s = ST_INIT;
      end
    endcase
  end

  // State and latched way register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_INIT;
      way_r   <= {CW{1'b0}};
    end else begin
      state_r <= state_s;
      way_r   <= way_s;
    end
  end

  // Registered outputs, settled before the counter bank's negedge update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_ready      <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_way        <= {CW{1'b0}};
      cnt_enable     <= 1'b0;
      cnt_reset      <= 1'b0;
      cnt_load       <= {WAYS{1'b0}};
      cnt_load_value <= {CW{1'b0}};
      cnt_decrement  <= {WAYS{1'b0}};
    end else begin
      req_ready      <= req_ready_s;
      rsp_valid      <= rsp_valid_s;
      rsp_way        <= rsp_way_s;
      cnt_enable     <= cnt_enable_s;
      cnt_reset      <= cnt_reset_s;
      cnt_load       <= cnt_load_s;
      cnt_load_value <= cnt_load_value_s;
      cnt_decrement  <= cnt_decrement_s;
    end
  end

endmodule
